// File: rtl/mult8_seq.sv
// Sequential shift-and-add unsigned multiplier: one partial-product add per clock
// through a single W-bit ripple adder. Optional MULT_ZERO_SKIP_EN short-cuts zero operands.
module mult8_seq #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    mcand_reg, mcand_next;
    logic [W-1:0]    acc_hi_reg, acc_hi_next;
    logic [W-1:0]    mult_lo_reg, mult_lo_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [2*W-1:0]  p_reg, p_next;

    logic [W-1:0]    addend;
    logic [W-1:0]    sum;
    logic            carry;
    logic [W-1:0]    acc_hi_shift;
    logic [W-1:0]    mult_lo_shift;

    assign addend = mult_lo_reg[0] ? mcand_reg : '0;

    adder8 #(.W(W)) u_adder (
        .a    (acc_hi_reg),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    // The carry is shifted into the accumulator, so no bit of the product is ever lost.
    assign acc_hi_shift  = {carry, sum[W-1:1]};
    assign mult_lo_shift = {sum[0], mult_lo_reg[W-1:1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            acc_hi_reg  <= '0;
            mult_lo_reg <= '0;
            count_reg   <= '0;
            p_reg       <= '0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            acc_hi_reg  <= acc_hi_next;
            mult_lo_reg <= mult_lo_next;
            count_reg   <= count_next;
            p_reg       <= p_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        acc_hi_next  = acc_hi_reg;
        mult_lo_next = mult_lo_reg;
        count_next   = count_reg;
        p_next       = p_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    mcand_next   = a;
                    mult_lo_next = b;
                    acc_hi_next  = '0;
                    count_next   = '0;
                    state_next   = RUN;
`ifdef MULT_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        p_next     = '0;
                        state_next = DONE;
                    end
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                acc_hi_next  = acc_hi_shift;
                mult_lo_next = mult_lo_shift;
                count_next   = count_reg + 1'b1;
                if (count_reg == CW'(W - 1)) begin
                    p_next     = {acc_hi_shift, mult_lo_shift};
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign p    = p_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// W-bit ripple-carry adder built from a chain of full-adder cells.
module adder8 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[W];

endmodule
